// File: rtl/banked_ram_pkg.sv
// banked_ram_pkg: state encoding, geometry helpers and parity for banked_ram.
`default_nettype none

package banked_ram_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b01,
    ST_IDLE  = 2'b10
  } state_t;

  localparam int PARITY_MAX_W = 64;

  function automatic int calc_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int calc_nbanks(input int bank_bits);
    return 1 << bank_bits;
  endfunction

  function automatic int calc_bank_depth(input int addr_w, input int bank_bits);
    return 1 << (addr_w - bank_bits);
  endfunction

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_bank.sv
// ram_bank: one bank of block RAM, synchronous write, registered read-first read.
`default_nettype none

module ram_bank
  import banked_ram_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam int BANK_WORDS = 1 << AW;

  logic [W-1:0] mem [0:BANK_WORDS-1];
  logic [W-1:0] rdata_q;
  logic [W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Array contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/banked_ram.sv
// banked_ram: parametrised banked data RAM with clear sequencer, ready/valid read.
// Define RAM_PARITY_EN to store an even-parity bit per word and flag read errors.
`default_nettype none

module banked_ram
  import banked_ram_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter int               ADDR_W         = 14,
  parameter int               BANK_BITS      = 2,
  parameter int               CLEAR_ON_RESET = 1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic              ready,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              parity_err
);

  localparam int NBANKS     = calc_nbanks(BANK_BITS);
  localparam int BANK_DEPTH = calc_bank_depth(ADDR_W, BANK_BITS);
  localparam int OFF_W      = ADDR_W - BANK_BITS;
`ifdef RAM_PARITY_EN
  localparam int MEM_W      = WIDTH + 1;
`else
  localparam int MEM_W      = WIDTH;
`endif
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     clr_ptr_q, clr_ptr_d;
  logic                  ready_q, ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [BANK_BITS-1:0]  sel_q, sel_d;

  logic                  w_idle;
  logic                  w_re;
  logic                  w_we;
  logic [ADDR_W-1:0]     w_waddr;
  logic [WIDTH-1:0]      w_wdata;
  logic [MEM_W-1:0]      w_wword;
  logic [MEM_W-1:0]      w_bank_rdata [NBANKS];
  logic [MEM_W-1:0]      w_rd_word;

  assign w_idle = ready_q && (state_q == ST_IDLE);
  assign w_re   = w_idle && rd_en;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
    ready_d     = (state_d == ST_IDLE);
    out_valid_d = w_re;
    sel_d       = w_re ? address[ADDR_W-1 -: BANK_BITS] : sel_q;
  end

  // The clear sequencer owns the shared write port while it runs.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = address;
    w_wdata = in;
    if (state_q == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = clr_ptr_q;
      w_wdata = CLEAR_VALUE;
    end else begin
      w_we    = w_idle && load;
    end
  end

`ifdef RAM_PARITY_EN
  assign w_wword = {even_parity(PARITY_MAX_W'(w_wdata)), w_wdata};
`else
  assign w_wword = w_wdata;
`endif

  generate
    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      ram_bank #(
        .W  (MEM_W),
        .AW (OFF_W)
      ) u_bank (
        .clk   (clk),
        .reset (reset),
        .we    (w_we && (w_waddr[ADDR_W-1 -: BANK_BITS] == BANK_BITS'(b))),
        .waddr (w_waddr[OFF_W-1:0]),
        .wdata (w_wword),
        .re    (w_re && (address[ADDR_W-1 -: BANK_BITS] == BANK_BITS'(b))),
        .raddr (address[OFF_W-1:0]),
        .rdata (w_bank_rdata[b])
      );
    end
  endgenerate

  assign w_rd_word = w_bank_rdata[sel_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RST_STATE;
      clr_ptr_q   <= '0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
    end
  end

  assign ready     = ready_q;
  assign out_valid = out_valid_q;
  assign out       = w_rd_word[WIDTH-1:0];

`ifdef RAM_PARITY_EN
  logic perr_q, perr_d;
  logic w_perr_now;

  assign w_perr_now = out_valid_q &&
                      (w_rd_word[WIDTH] != even_parity(PARITY_MAX_W'(w_rd_word[WIDTH-1:0])));

  // Sticky until a clear is accepted or reset; shows in the same cycle as out_valid.
  always_comb begin
    perr_d = perr_q | w_perr_now;
    if (state_q == ST_IDLE && clear) perr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end

  assign parity_err = perr_q | w_perr_now;
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/banked_ram.md
Name: banked_ram

Overview:
- Parametrised successor to the fixed 16-bit banked RAM chips. Width, depth and bank count are generic.
- Adds a registered read with a valid strobe, a ready handshake, and a hardware clear sequencer that runs after reset or on request.
- Sits between the Hack CPU/memory-map glue and on-chip block RAM, as the data memory.

Parameters:
- WIDTH, 16, data word width in bits
- ADDR_W, 14, address width; DEPTH = 2**ADDR_W words
- BANK_BITS, 2, bank-select bits; NBANKS = 2**BANK_BITS; bank = address[ADDR_W-1 -: BANK_BITS]
- CLEAR_ON_RESET, 1, 1 = run clear sequence after reset release; 0 = go straight to IDLE
- CLEAR_VALUE, 0, WIDTH-bit value written to every word during clear

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in  input  WIDTH  write data
- load  input  1  write strobe, qualified by ready
- rd_en  input  1  read strobe, qualified by ready
- address  input  ADDR_W  word address for read and write
- clear  input  1  synchronous request to re-run the clear sequence
- ready  output  1  1 = accepting load/rd_en
- out  output  WIDTH  registered read data
- out_valid  output  1  one-cycle pulse; out holds new read data
- parity_err  output  1  parity error flag (RAM_PARITY_EN only, else tied 0)

Behaviour:
- Reset asserted (async):
  - state = CLEAR if CLEAR_ON_RESET, else IDLE; clr_ptr = 0.
  - ready = 0, out = 0, out_valid = 0, parity_err = 0.
  - Array contents are not reset by reset itself.
- Reset deasserted: first active edge begins the state's operation.
- CLEAR state:
  - Each cycle writes CLEAR_VALUE to word clr_ptr, then increments clr_ptr.
  - The write to DEPTH-1 moves the block to IDLE; ready = 1 the following cycle.
  - Total clear = DEPTH cycles after reset release.
  - load, rd_en and clear are ignored; no out_valid.
- IDLE state:
  - ready = 1.
  - load = 1: in is written to address at the edge.
  - rd_en = 1: out = mem[address] at the next edge, out_valid = 1 for exactly that cycle.
  - out holds its value until the next accepted read.
  - Latency is 1 cycle; back-to-back reads give continuous out_valid.
- Simultaneous load and rd_en, same address: read-first; out returns the old data and the write lands. Different addresses: both operate independently.
- clear = 1 in IDLE:
  - At that edge: state = CLEAR, clr_ptr = 0, ready = 0 next cycle.
  - A load or rd_en in the same cycle is still accepted (precedes the clear).
- Reset mid-clear: clr_ptr restarts at 0 and the full sequence reruns.
- Banking: only the selected bank's write enable is active. Read data is muxed using the bank bits registered with the read.
- Address space is exactly DEPTH words; no out-of-range case.
- States: CLEAR, IDLE. Any illegal encoding recovers to CLEAR.

Optional Feature:
- Macro: RAM_PARITY_EN
- Defined:
  - Each word stores one extra even-parity bit, computed on write; clear writes correct parity.
  - On a read, parity_err = 1 alongside out_valid if stored parity mismatches recomputed parity; it is sticky until reset or clear.
- Undefined: no parity storage; parity_err is constant 0.

Decomposition:
- Package banked_ram_pkg:
  - state encoding constants ST_CLEAR, ST_IDLE
  - DEPTH / NBANKS / BANK_DEPTH derivation helpers
  - parity function
- Sub-module ram_bank:
  - one bank of BANK_DEPTH words, WIDTH (+1 with parity) bits
  - synchronous write, registered read
  - instantiated NBANKS times via generate
- Top-level banked_ram: clear FSM, bank decode, output mux.

Test Plan:
- Reset, default params -> ready = 0 for 16384 cycles after release, then 1. A read of 0x3FFF returns 0x0000 with out_valid one cycle after rd_en.
- Write 0xBEEF @0x0005 and 0x1234 @0x2005 (different bank, same offset), read both -> 0xBEEF then 0x1234 on consecutive cycles, out_valid high 2 cycles.
- Write 0x1111 @0x0100, then load 0x2222 + rd_en same cycle @0x0100 -> out = 0x1111; next read -> 0x2222.
- load and rd_en held during clear -> no out_valid, and after ready the written address still reads CLEAR_VALUE. Pulse clear in IDLE -> ready drops for DEPTH cycles and previously written words read 0.
- Reset asserted at clear cycle 100 -> ready stays 0 for the full DEPTH cycles after re-release. With CLEAR_ON_RESET = 0 -> ready = 1 on the first cycle after release.
- RAM_PARITY_EN: force-flip a stored data bit via the bench, read it -> parity_err = 1 with out_valid and remains 1 until clear. Without the macro -> parity_err stays 0.
